// File: rtl/logic_op_sequencer.sv
// Multi-cycle bitwise logic unit: eight opcodes built from a shared AND/OR/NOT
// primitive, one primitive per cycle, with valid/ready on both sides.
module logic_op_sequencer #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [2:0]       out_op,
    output logic             busy,
    output logic [CNT_W-1:0] done_count
);

    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
    typedef enum logic [1:0] {P_AND, P_OR, P_NOT} prim_t;
    typedef enum logic [2:0] {S_A, S_B, S_T0, S_T1, S_R} src_t;
    typedef enum logic [1:0] {D_T0, D_T1, D_R} dst_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, b_q, t0_q, t1_q, res_q;
    logic [2:0]       op_q, step_q;
    logic [CNT_W-1:0] cnt_q;

    prim_t            prim;
    src_t             sx, sy;
    dst_t             dst;
    logic             last;
    logic [WIDTH-1:0] xv, yv, pv;

    // Micro-sequence decode: (opcode, step) -> primitive, sources, destination.
    always_comb begin
        prim = P_AND;
        sx   = S_A;
        sy   = S_B;
        dst  = D_R;
        last = 1'b1;
        case (op_q)
            3'd0: prim = P_AND;
            3'd1: prim = P_OR;
            3'd2: prim = P_NOT;
            3'd3, 3'd4: begin
                if (step_q == 3'd0) begin
                    prim = (op_q == 3'd3) ? P_AND : P_OR;
                    dst  = D_T0;
                    last = 1'b0;
                end else begin
                    prim = P_NOT;
                    sx   = S_T0;
                end
            end
            3'd5, 3'd6: begin
                case (step_q)
                    3'd0: begin prim = P_OR;  dst = D_T0; last = 1'b0; end
                    3'd1: begin prim = P_AND; dst = D_T1; last = 1'b0; end
                    3'd2: begin prim = P_NOT; sx = S_T1; dst = D_T1; last = 1'b0; end
                    3'd3: begin prim = P_AND; sx = S_T0; sy = S_T1; last = (op_q == 3'd5); end
                    default: begin prim = P_NOT; sx = S_R; end
                endcase
            end
            default: begin
                if (step_q == 3'd0) begin
                    prim = P_NOT;
                    sx   = S_B;
                    dst  = D_T1;
                    last = 1'b0;
                end else begin
                    prim = P_AND;
                    sy   = S_T1;
                end
            end
        endcase
    end

    always_comb begin
        case (sx)
            S_A:     xv = a_q;
            S_B:     xv = b_q;
            S_T0:    xv = t0_q;
            S_T1:    xv = t1_q;
            default: xv = res_q;
        endcase
        case (sy)
            S_A:     yv = a_q;
            S_B:     yv = b_q;
            S_T0:    yv = t0_q;
            S_T1:    yv = t1_q;
            default: yv = res_q;
        endcase
        case (prim)
            P_AND:   pv = xv & yv;
            P_OR:    pv = xv | yv;
            default: pv = ~xv;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid) state_d = EXEC;
            EXEC:    if (last) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q    <= '0;
            b_q    <= '0;
            t0_q   <= '0;
            t1_q   <= '0;
            res_q  <= '0;
            op_q   <= '0;
            step_q <= '0;
            cnt_q  <= '0;
        end else begin
            case (state_q)
                IDLE: if (in_valid) begin
                    a_q    <= in_a;
                    b_q    <= in_b;
                    op_q   <= in_op;
                    step_q <= '0;
                end
                EXEC: begin
                    case (dst)
                        D_T0:    t0_q  <= pv;
                        D_T1:    t1_q  <= pv;
                        default: res_q <= pv;
                    endcase
                    step_q <= step_q + 3'd1;
                end
                DONE: if (out_ready) cnt_q <= cnt_q + CNT_W'(1);
                default: ;
            endcase
        end
    end

    assign in_ready   = (state_q == IDLE);
    assign out_valid  = (state_q == DONE);
    assign busy       = (state_q != IDLE);
    assign out_result = res_q;
    assign out_op     = op_q;
    assign done_count = cnt_q;

endmodule

// File: tb/tb_logic_op_sequencer.sv
// Bench for logic_op_sequencer: directed vector table, stall/ignore/reset/wrap
// sequences and randomized ops against a plain-operator reference model.
module tb_logic_op_sequencer;

    localparam int W  = 32;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [2:0]    in_op = '0;
    logic [W-1:0]  in_a = '0;
    logic [W-1:0]  in_b = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [W-1:0]  out_result;
    logic [2:0]    out_op;
    logic          busy;
    logic [CW-1:0] done_count;

    int total = 0;
    int bad   = 0;
    int cnt   = 0;

    logic_op_sequencer #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_a(in_a), .in_b(in_b),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_op(out_op),
        .busy(busy), .done_count(done_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]   op;
        logic [W-1:0] a, b, r;
        int           n;
    } vec_t;

    vec_t tbl[8];

    function automatic logic [W-1:0] ref_res(input logic [2:0] op, input logic [W-1:0] a, b);
        case (op)
            3'd0: return a & b;
            3'd1: return a | b;
            3'd2: return ~a;
            3'd3: return ~(a & b);
            3'd4: return ~(a | b);
            3'd5: return a ^ b;
            3'd6: return ~(a ^ b);
            default: return a & ~b;
        endcase
    endfunction

    function automatic int ref_lat(input logic [2:0] op);
        case (op)
            3'd3, 3'd4, 3'd7: return 2;
            3'd5: return 4;
            3'd6: return 5;
            default: return 1;
        endcase
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Full transaction: accept, latency count, optional stall, handshake.
    task automatic do_op(input logic [2:0] op, input logic [W-1:0] a, b,
                         input int exp_n, input logic [W-1:0] exp_r,
                         input int stall, input bit inject);
        int k;
        chk("in_ready_idle", in_ready, 1);
        in_op = op; in_a = a; in_b = b; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("busy_exec", busy, 1);
        chk("in_ready_exec", in_ready, 0);
        if (inject) begin
            in_valid = 1'b1; in_a = ~a; in_b = a ^ 32'h5a5a_a5a5; in_op = 3'(op + 3'd1);
        end
        k = 0;
        while (!out_valid && k < 12) begin
            @(posedge clk); #1;
            k++;
            if (inject && !out_valid) chk("ignored_req_ready", in_ready, 0);
        end
        in_valid = 1'b0;
        chk("latency", k, exp_n);
        chk("result", out_result, exp_r);
        chk("out_op", out_op, op);
        chk("count_before", done_count, cnt);
        for (int s = 0; s < stall; s++) begin
            @(posedge clk); #1;
            chk("stall_valid", out_valid, 1);
            chk("stall_result", out_result, exp_r);
            chk("stall_count", done_count, cnt);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        cnt = (cnt + 1) % (1 << CW);
        chk("count_after", done_count, cnt);
        chk("in_ready_after", in_ready, 1);
        chk("valid_after", out_valid, 0);
        chk("result_held", out_result, exp_r);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_result", out_result, 0);
        chk("rst_out_op", out_op, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done_count", done_count, 0);
        rst_n = 1'b1;
        cnt = 0;
    endtask

    initial begin
        logic [W-1:0] ta, tb, ra, rb;
        logic [2:0]   rop;
        ta = 32'hF0F0_1234;
        tb = 32'h0FF0_FF00;
        tbl[0] = '{3'd0, ta, tb, 32'h00F0_1200, 1};
        tbl[1] = '{3'd1, ta, tb, 32'hFFF0_FF34, 1};
        tbl[2] = '{3'd2, ta, tb, 32'h0F0F_EDCB, 1};
        tbl[3] = '{3'd3, ta, tb, 32'hFF0F_EDFF, 2};
        tbl[4] = '{3'd4, ta, tb, 32'h000F_00CB, 2};
        tbl[5] = '{3'd5, ta, tb, 32'hFF00_ED34, 4};
        tbl[6] = '{3'd6, ta, tb, 32'h00FF_12CB, 5};
        tbl[7] = '{3'd7, ta, tb, 32'hF000_0034, 2};

        do_reset();

        // Directed vectors
        for (int i = 0; i < 8; i++)
            do_op(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].n, tbl[i].r, 0, 1'b0);

        // XNOR with a 6-cycle stall
        do_op(3'd6, ta, tb, 5, 32'h00FF_12CB, 6, 1'b0);

        // XOR with a competing request during EXEC
        do_op(3'd5, ta, tb, 4, 32'hFF00_ED34, 0, 1'b1);

        // Reset pulse at step 2 of XOR aborts everything
        in_op = 3'd5; in_a = ta; in_b = tb; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_out_valid", out_valid, 0);
        chk("abort_out_result", out_result, 0);
        chk("abort_out_op", out_op, 0);
        chk("abort_busy", busy, 0);
        chk("abort_in_ready", in_ready, 1);
        chk("abort_done_count", done_count, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        cnt = 0;
        do_op(3'd0, ta, tb, 1, 32'h00F0_1200, 0, 1'b0);

        // 16 back-to-back NOTs wrap the 4-bit counter
        do_reset();
        for (int i = 0; i < (1 << CW); i++) begin
            ra = $urandom;
            do_op(3'd2, ra, $urandom, 1, ~ra, 0, 1'b0);
        end
        chk("wrap_zero", done_count, 0);

        // Randomized ops vs reference model
        for (int i = 0; i < 40; i++) begin
            rop = 3'($urandom_range(0, 7));
            ra  = $urandom;
            rb  = $urandom;
            do_op(rop, ra, rb, ref_lat(rop), ref_res(rop, ra, rb),
                  $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
